// File: rtl/riscv_pkg.sv
// Shared RV32 encodings for the M-extension unit and its FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_REG       = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_SIGN = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and conditional 64-bit two's-complement negate.
module muldiv_sign_fix (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_a_signed,
  input  logic        i_b_signed,
  input  logic [63:0] i_val,
  input  logic        i_neg,
  output logic [31:0] o_a_abs,
  output logic [31:0] o_b_abs,
  output logic [63:0] o_val
);

  always_comb begin
    o_a_abs = (i_a_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
    o_b_abs = (i_b_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;
    o_val   = i_neg ? (~i_val + 64'd1) : i_val;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX: 32-step shift-add / restoring divide,
// with a one-cycle fast path for divide-by-zero and signed overflow.
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_func_3,
  input  logic [6:0]      i_func_7,
  input  logic [XLEN-1:0] i_rs_1,
  input  logic [XLEN-1:0] i_rs_2,
  input  logic [4:0]      i_rd_num,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_num,
  output muldiv_state_e   o_dbg_state
);

  muldiv_state_e     state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              req;
  logic              a_signed, b_signed, s_a, s_b;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] sign_val, val_fixed;
  logic [XLEN:0]     mul_sum, rem_shift, div_diff;
  logic [XLEN-1:0]   res_sel;

  assign req = i_valid && (i_opcode == OP_REG) && (i_func_7 == FUNC7_MULDIV);

  always_comb begin
    a_signed = (i_func_3 == F3_MULH) || (i_func_3 == F3_MULHSU) ||
               (i_func_3 == F3_DIV)  || (i_func_3 == F3_REM);
    b_signed = (i_func_3 == F3_MULH) || (i_func_3 == F3_DIV) || (i_func_3 == F3_REM);
    s_a      = a_signed && i_rs_1[XLEN-1];
    s_b      = b_signed && i_rs_2[XLEN-1];
  end

  // Division keeps the quotient in acc_q[31:0]; the remainder is selected instead for REM/REMU.
  always_comb begin
    if (!op_q[2])     sign_val = acc_q;
    else if (op_q[1]) sign_val = {{XLEN{1'b0}}, rem_q};
    else              sign_val = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
  end

  muldiv_sign_fix u_sign_fix (
    .i_a        (i_rs_1),
    .i_b        (i_rs_2),
    .i_a_signed (a_signed),
    .i_b_signed (b_signed),
    .i_val      (sign_val),
    .i_neg      (neg_q),
    .o_a_abs    (a_abs),
    .o_b_abs    (b_abs),
    .o_val      (val_fixed)
  );

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = rem_shift - {1'b0, opnd_q};
    res_sel   = ((op_q == F3_MUL) || op_q[2]) ? val_fixed[XLEN-1:0] : val_fixed[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    valid_d  = 1'b0;
    result_d = result_q;
    if (i_flush) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (req) begin
            op_d  = i_func_3;
            rd_d  = i_rd_num;
            cnt_d = '0;
            if (i_func_3[2] && (i_rs_2 == '0)) begin
              result_d = i_func_3[1] ? i_rs_1 : '1;
              valid_d  = 1'b1;
              state_d  = MD_DONE;
            end else if (((i_func_3 == F3_DIV) || (i_func_3 == F3_REM)) &&
                         (i_rs_1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs_2 == '1)) begin
              result_d = i_func_3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
              valid_d  = 1'b1;
              state_d  = MD_DONE;
            end else begin
              rem_d   = '0;
              state_d = MD_CALC;
              if (i_func_3[2]) begin
                acc_d  = {{XLEN{1'b0}}, a_abs};
                opnd_d = b_abs;
                neg_d  = i_func_3[1] ? s_a : (s_a ^ s_b);
              end else begin
                acc_d  = {{XLEN{1'b0}}, b_abs};
                opnd_d = a_abs;
                neg_d  = s_a ^ s_b;
              end
            end
          end
        end
        MD_CALC: begin
          if (op_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
            rem_d = div_diff[XLEN] ? rem_shift[XLEN-1:0] : div_diff[XLEN-1:0];
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = MD_SIGN;
        end
        MD_SIGN: begin
          result_d = res_sel;
          valid_d  = 1'b1;
          state_d  = MD_DONE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Released in DONE so the pipeline advances on the same edge the result is written back.
  assign o_stall     = !i_rst && (((state_q == MD_IDLE) && req) ||
                                  (state_q == MD_CALC) || (state_q == MD_SIGN));
  assign o_valid     = valid_q;
  assign o_result    = result_q;
  assign o_rd_num    = rd_q;
  assign o_dbg_state = state_q;

endmodule
